// File: rtl/hold_seq.sv
// hold_seq: run sequencer with pause/hold, abort, one-shot or continuous relaunch.
// Outputs are registered from the next-state decode so they line up with the state.
module hold_seq #(
   parameter int unsigned CNT_W   = 4,
   parameter int unsigned DEF_LEN = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [CNT_W-1:0] len,
   input  logic             pause,
   input  logic             abort,
   output logic             g,
   output logic             f,
   output logic             done,
   output logic             busy,
   output logic [CNT_W-1:0] cnt,
   output logic [7:0]       laps
);

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEF_LEN_C = CNT_W'(DEF_LEN);

   typedef enum logic [1:0] {IDLE, RUN, HOLD, LAST} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] launch_len;
   logic             f_q, f_d;
   logic [7:0]       laps_q, laps_d;
   logic             g_q, done_q, busy_q;
   logic             at_end;

   assign launch_len = (len == '0) ? DEF_LEN_C : len;
   assign at_end     = (cnt_q == len_q - ONE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               state_d = RUN;
               len_d   = launch_len;
            end
         end
         // HOLD shares RUN's decode: leaving HOLD takes the count step that
         // the paused RUN cycle skipped, so each cnt value appears once in RUN.
         RUN, HOLD: begin
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (pause) begin
               state_d = HOLD;
            end else if (at_end) begin
               state_d = LAST;
            end else begin
               state_d = RUN;
               cnt_d   = cnt_q + ONE;
            end
         end
         LAST: begin
            cnt_d = '0;
            if (mode && !abort) begin
               state_d = RUN;
               len_d   = launch_len;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign f_d    = (state_d == LAST) ? ~f_q : f_q;
   assign laps_d = (state_d == LAST) ? laps_q + 8'd1 : laps_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         f_q     <= 1'b0;
         laps_q  <= '0;
         g_q     <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         f_q     <= f_d;
         laps_q  <= laps_d;
         g_q     <= (state_d == RUN) || (state_d == HOLD);
         done_q  <= (state_d == LAST);
         busy_q  <= (state_d != IDLE);
      end
   end

   assign g    = g_q;
   assign f    = f_q;
   assign done = done_q;
   assign busy = busy_q;
   assign cnt  = cnt_q;
   assign laps = laps_q;

endmodule

// File: tb/tb_hold_seq.sv
// Directed self-checking bench for hold_seq; expected values are hand-derived
// and tracked with a small f/laps model.
module tb_hold_seq;

   localparam int unsigned CNT_W = 4;
   localparam logic [2:0] S_RUN  = 3'b101;  // {g,done,busy}; HOLD looks the same
   localparam logic [2:0] S_LAST = 3'b011;
   localparam logic [2:0] S_IDLE = 3'b000;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b1;
   logic             start = 1'b0;
   logic             mode  = 1'b0;
   logic [CNT_W-1:0] len   = '0;
   logic             pause = 1'b0;
   logic             abort = 1'b0;
   logic             g, f, done, busy;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       laps;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   int unsigned g_cycles = 0;
   int unsigned d_pulses = 0;
   int unsigned base_g, base_d;
   logic        exp_f    = 1'b0;
   logic [7:0]  exp_laps = '0;

   always #5 clk = ~clk;

   hold_seq #(.CNT_W(CNT_W), .DEF_LEN(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .len(len),
      .pause(pause), .abort(abort), .g(g), .f(f), .done(done),
      .busy(busy), .cnt(cnt), .laps(laps)
   );

   always @(negedge clk) begin
      if (g)    g_cycles <= g_cycles + 1;
      if (done) d_pulses <= d_pulses + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic st(input string tag, input logic [2:0] gdb, input int unsigned c);
      check({tag, ".gdb"}, 32'({g, done, busy}), 32'(gdb));
      check({tag, ".cnt"}, 32'(cnt), c);
   endtask

   task automatic fl(input string tag);
      check({tag, ".f"},    32'(f),    32'(exp_f));
      check({tag, ".laps"}, 32'(laps), 32'(exp_laps));
   endtask

   task automatic lap_end(input string tag);
      exp_f    = ~exp_f;
      exp_laps = exp_laps + 8'd1;
      check({tag, ".gdb"}, 32'({g, done, busy}), 32'(S_LAST));
      fl(tag);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // reset is asynchronous: outputs must clear before any clock edge
      #2 rst_n = 1'b0;
      #1;
      st("rst", S_IDLE, 0);
      fl("rst");
      start = 1'b1;
      tick();
      st("rst_held", S_IDLE, 0);
      start = 1'b0;
      tick();
      rst_n = 1'b1;

      // 1: default length one-shot
      len = '0; mode = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) tick();
         st("s1_run", S_RUN, i);
      end
      tick(); lap_end("s1_last");
      tick(); st("s1_idle", S_IDLE, 0); fl("s1_idle");

      // 2: continuous mode, mode dropped mid third lap
      len = 4'd3; mode = 1'b1; start = 1'b1;
      for (int lap = 0; lap < 3; lap++) begin
         for (int c = 0; c < 3; c++) begin
            tick();
            start = 1'b0;
            st("s2_run", S_RUN, c);
            if (lap == 2 && c == 1) mode = 1'b0;
         end
         tick(); lap_end("s2_last");
      end
      tick(); st("s2_idle", S_IDLE, 0); fl("s2_idle");

      // 3: pause at cnt=2 for 4 cycles; len change mid-run must not matter
      len = 4'd5; mode = 1'b0; start = 1'b1;
      base_g = g_cycles; base_d = d_pulses;
      tick(); start = 1'b0; len = 4'd1; st("s3_run", S_RUN, 0);
      tick(); st("s3_run", S_RUN, 1);
      tick(); st("s3_run", S_RUN, 2);
      pause = 1'b1;
      for (int h = 0; h < 4; h++) begin
         tick(); st("s3_hold", S_RUN, 2);
      end
      pause = 1'b0;
      tick(); st("s3_run", S_RUN, 3);
      tick(); st("s3_run", S_RUN, 4);
      tick(); lap_end("s3_last");
      tick(); st("s3_idle", S_IDLE, 0);
      check("s3_g_cycles", g_cycles - base_g, 9);
      check("s3_done_pulses", d_pulses - base_d, 1);

      // 4: abort in RUN, abort in HOLD, abort in LAST
      len = 4'd4; mode = 1'b0; start = 1'b1;
      base_d = d_pulses;
      tick(); start = 1'b0; st("s4a_run", S_RUN, 0);
      tick(); st("s4a_run", S_RUN, 1);
      abort = 1'b1;
      tick(); abort = 1'b0;
      st("s4a_idle", S_IDLE, 0); fl("s4a_idle");
      start = 1'b1;
      tick(); start = 1'b0; st("s4b_run", S_RUN, 0);
      tick(); st("s4b_run", S_RUN, 1);
      pause = 1'b1;
      tick(); st("s4b_hold", S_RUN, 1);
      abort = 1'b1;
      tick(); abort = 1'b0; pause = 1'b0;
      st("s4b_idle", S_IDLE, 0); fl("s4b_idle");
      check("s4_done_pulses", d_pulses - base_d, 0);
      len = 4'd2; mode = 1'b1; start = 1'b1;
      tick(); start = 1'b0; st("s4c_run", S_RUN, 0);
      tick(); st("s4c_run", S_RUN, 1);
      tick(); lap_end("s4c_last");
      abort = 1'b1;
      tick(); abort = 1'b0; mode = 1'b0;
      st("s4c_idle", S_IDLE, 0); fl("s4c_idle");

      // 5: asynchronous reset mid-run with start held
      len = 4'd5; start = 1'b1;
      tick(); st("s5_run", S_RUN, 0);
      tick(); st("s5_run", S_RUN, 1);
      #2 rst_n = 1'b0;
      #1;
      exp_f = 1'b0; exp_laps = '0;
      st("s5_async", S_IDLE, 0); fl("s5_async");
      tick(); st("s5_held", S_IDLE, 0);
      rst_n = 1'b1;
      tick(); st("s5_first_run", S_RUN, 0);
      start = 1'b0; abort = 1'b1;
      tick(); abort = 1'b0;
      st("s5_idle", S_IDLE, 0); fl("s5_idle");

      // 6: len=1, start held, 256 laps -> laps wraps, f back to 0
      len = 4'd1; mode = 1'b0; start = 1'b1;
      for (int k = 0; k < 256; k++) begin
         tick(); st("s6_run", S_RUN, 0);
         tick(); lap_end("s6_last");
         tick(); check("s6_idle", 32'({g, done, busy}), 32'(S_IDLE));
      end
      start = 1'b0;
      check("s6_laps_wrap", 32'(laps), 32'd0);
      check("s6_f_restored", 32'(f), 32'd0);
      tick(); st("s6_stop", S_IDLE, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
